// File: rtl/tx_frame_fetch.sv
// Transmit-side frame fetcher: reads one frame from the ping-pong buffer and
// streams header, payload and optional CRC-16/MODBUS bytes to the serializer.
module tx_frame_fetch #(
  parameter int A_WIDTH = 8,
  parameter int CRC_EN  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               abort,
  input  logic               unread,
  output logic [A_WIDTH-1:0] rd_addr,
  input  logic [7:0]         rd_byte,
  output logic               rd_done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               busy,
  output logic               len_err
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_RD  = 4'd1,
    ST_LEN_LAT = 4'd2,
    ST_B_RD    = 4'd3,
    ST_B_LAT   = 4'd4,
    ST_SEND    = 4'd5,
    ST_CRC_L   = 4'd6,
    ST_CRC_H   = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam logic [A_WIDTH:0] TOTAL_MAX = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic             CRC_ON    = (CRC_EN != 0);

  // Reflected CRC-16/MODBUS, one byte per call
  function automatic logic [15:0] crc_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_t             state_r;
  logic [A_WIDTH-1:0] rd_addr_r;
  logic [7:0]         tx_data_r;
  logic               tx_valid_r;
  logic               tx_last_r;
  logic               rd_done_r;
  logic               busy_r;
  logic               len_err_r;
  logic [15:0]        crc_r;
  logic [A_WIDTH:0]   idx_r;
  logic [A_WIDTH:0]   total_r;

  logic [15:0]        crc_next_s;
  logic [A_WIDTH:0]   len_sum_s;
  logic [A_WIDTH:0]   len_total_s;
  logic               len_clamp_s;
  logic               is_last_s;
  logic               hs_s;

  assign rd_addr  = rd_addr_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign tx_last  = tx_last_r;
  assign rd_done  = rd_done_r;
  assign busy     = busy_r;
  assign len_err  = len_err_r;

  // Next CRC, clamped frame length and handshake decode
  always_comb begin
    crc_next_s = crc_update(crc_r, tx_data_r);
    len_sum_s  = (A_WIDTH+1)'(rd_byte) + (A_WIDTH+1)'(3);
    if (len_sum_s > TOTAL_MAX) begin
      len_total_s = TOTAL_MAX;
      len_clamp_s = 1'b1;
    end else begin
      len_total_s = len_sum_s;
      len_clamp_s = 1'b0;
    end
    is_last_s = (idx_r == (total_r - (A_WIDTH+1)'(1)));
    hs_s      = tx_valid_r & tx_ready;
  end

  // Fetch/stream state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      rd_addr_r  <= {A_WIDTH{1'b0}};
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      tx_last_r  <= 1'b0;
      rd_done_r  <= 1'b0;
      busy_r     <= 1'b0;
      len_err_r  <= 1'b0;
      crc_r      <= 16'hFFFF;
      idx_r      <= {(A_WIDTH+1){1'b0}};
      total_r    <= {(A_WIDTH+1){1'b0}};
    end else begin
      rd_done_r <= 1'b0;
      len_err_r <= 1'b0;
      // DONE already carries the release pulse, so abort there must not add a second one
      if (abort && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
        state_r    <= ST_IDLE;
        tx_valid_r <= 1'b0;
        tx_last_r  <= 1'b0;
        rd_done_r  <= 1'b1;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (en && unread && !abort) begin
              rd_addr_r <= A_WIDTH'(2);
              crc_r     <= 16'hFFFF;
              busy_r    <= 1'b1;
              state_r   <= ST_LEN_RD;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_LEN_RD: state_r <= ST_LEN_LAT;
          ST_LEN_LAT: begin
            total_r   <= len_total_s;
            len_err_r <= len_clamp_s;
            idx_r     <= {(A_WIDTH+1){1'b0}};
            rd_addr_r <= {A_WIDTH{1'b0}};
            state_r   <= ST_B_RD;
          end
          ST_B_RD: state_r <= ST_B_LAT;
          ST_B_LAT: begin
            tx_data_r  <= rd_byte;
            tx_valid_r <= 1'b1;
            tx_last_r  <= is_last_s & ~CRC_ON;
            state_r    <= ST_SEND;
          end
          ST_SEND: begin
            if (hs_s) begin
              crc_r <= crc_next_s;
              idx_r <= idx_r + (A_WIDTH+1)'(1);
              if (is_last_s) begin
                if (CRC_ON) begin
                  tx_data_r  <= crc_next_s[7:0];
                  tx_valid_r <= 1'b1;
                  tx_last_r  <= 1'b0;
                  state_r    <= ST_CRC_L;
                end else begin
                  tx_valid_r <= 1'b0;
                  tx_last_r  <= 1'b0;
                  rd_done_r  <= 1'b1;
                  state_r    <= ST_DONE;
                end
              end else begin
                tx_valid_r <= 1'b0;
                tx_last_r  <= 1'b0;
                rd_addr_r  <= idx_r[A_WIDTH-1:0] + A_WIDTH'(1);
                state_r    <= ST_B_RD;
              end
            end else begin
              state_r <= ST_SEND;
            end
          end
          ST_CRC_L: begin
            if (hs_s) begin
              tx_data_r <= crc_r[15:8];
              tx_last_r <= 1'b1;
              state_r   <= ST_CRC_H;
            end else begin
              state_r <= ST_CRC_L;
            end
          end
          ST_CRC_H: begin
            if (hs_s) begin
              tx_valid_r <= 1'b0;
              tx_last_r  <= 1'b0;
              rd_done_r  <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              state_r <= ST_CRC_H;
            end
          end
          ST_DONE: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_fetch.sv
// Directed bench for tx_frame_fetch: CRC build (dut0) and no-CRC build (dut1)
// fed from behavioural one-cycle-latency buffer models.
module tb_tx_frame_fetch;

  logic       clk = 1'b0;
  logic       reset_n, en, abort;
  logic       unread0, unread1, tx_ready0, tx_ready1;
  logic [7:0] rd_addr0, rd_addr1, rd_byte0, rd_byte1;
  logic [7:0] tx_data0, tx_data1;
  logic       rd_done0, rd_done1, tx_valid0, tx_valid1, tx_last0, tx_last1;
  logic       busy0, busy1, len_err0, len_err1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] exp_q [$];
  int         n_vec = 0, n_bad = 0;
  int         done_cnt0 = 0, done_cnt1 = 0, lenerr_cnt0 = 0;

  always #5 clk = ~clk;

  tx_frame_fetch #(.A_WIDTH(8), .CRC_EN(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .abort(abort), .unread(unread0),
    .rd_addr(rd_addr0), .rd_byte(rd_byte0), .rd_done(rd_done0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx_last(tx_last0), .busy(busy0), .len_err(len_err0)
  );

  tx_frame_fetch #(.A_WIDTH(8), .CRC_EN(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .abort(abort), .unread(unread1),
    .rd_addr(rd_addr1), .rd_byte(rd_byte1), .rd_done(rd_done1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx_last(tx_last1), .busy(busy1), .len_err(len_err1)
  );

  // Buffer read port: data one clock after the address
  always @(posedge clk) begin
    rd_byte0 <= mem0[rd_addr0];
    rd_byte1 <= mem1[rd_addr1];
  end

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rd_done0) done_cnt0++;
    if (rd_done1) done_cnt1++;
    if (len_err0) lenerr_cnt0++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Golden CRC-16/MODBUS, processed bit by bit
  function automatic logic [15:0] crc_model(input logic [7:0] q [$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic build_exp(input int which, input int crc_en);
    int          total;
    logic [15:0] c;
    total = 3 + ((which == 0) ? int'(mem0[2]) : int'(mem1[2]));
    if (total > 256) total = 256;
    exp_q = {};
    for (int i = 0; i < total; i++) exp_q.push_back((which == 0) ? mem0[i] : mem1[i]);
    if (crc_en != 0) begin
      c = crc_model(exp_q);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
  endtask

  // stop_kind: 0 run to completion, 1 abort, 2 reset pulse when byte stop_at is offered
  task automatic run_frame(input int which, input int duty, input int stop_at, input int stop_kind);
    int   k, cyc;
    logic v, l, r;
    logic [7:0] d;
    @(posedge clk); #1;
    if (which == 0) unread0 = 1'b1; else unread1 = 1'b1;
    @(posedge clk); #1;
    unread0 = 1'b0; unread1 = 1'b0;
    check_val("busy_start", (which == 0) ? busy0 : busy1, 1);
    check_val("rd_addr_len", (which == 0) ? rd_addr0 : rd_addr1, 2);
    k = 0; cyc = 0;
    while (k < exp_q.size() && cyc < 3000) begin
      cyc++;
      v = (which == 0) ? tx_valid0 : tx_valid1;
      if (stop_kind != 0 && v && k == stop_at) begin
        tx_ready0 = 1'b0; tx_ready1 = 1'b0;
        if (stop_kind == 1) abort = 1'b1; else reset_n = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0; reset_n = 1'b1;
        break;
      end
      r = (duty >= 100) || ($urandom_range(0, 99) < duty);
      if (which == 0) tx_ready0 = r; else tx_ready1 = r;
      @(negedge clk);
      v = (which == 0) ? tx_valid0 : tx_valid1;
      d = (which == 0) ? tx_data0 : tx_data1;
      l = (which == 0) ? tx_last0 : tx_last1;
      if (v) begin
        check_val("tx_data", d, exp_q[k]);
        check_val("tx_last", l, (k == exp_q.size() - 1));
        if (r) k++;
      end
      @(posedge clk); #1;
    end
    if (stop_kind == 0) begin
      check_val("bytes_sent", k, exp_q.size());
      check_val("rd_done_after_last", (which == 0) ? rd_done0 : rd_done1, 1);
      check_val("valid_after_last", (which == 0) ? tx_valid0 : tx_valid1, 0);
      @(posedge clk); #1;
      check_val("rd_done_one_clk", (which == 0) ? rd_done0 : rd_done1, 0);
      check_val("busy_end", (which == 0) ? busy0 : busy1, 0);
    end else if (stop_kind == 1) begin
      check_val("abort_valid", tx_valid0, 0);
      check_val("abort_rd_done", rd_done0, 1);
      check_val("abort_busy", busy0, 0);
      @(posedge clk); #1;
      check_val("abort_rd_done_clr", rd_done0, 0);
    end else begin
      check_val("rst_valid", tx_valid0, 0);
      check_val("rst_data", tx_data0, 0);
      check_val("rst_last", tx_last0, 0);
      check_val("rst_addr", rd_addr0, 0);
      check_val("rst_done", rd_done0, 0);
      check_val("rst_busy", busy0, 0);
      check_val("rst_len_err", len_err0, 0);
    end
  endtask

  initial begin
    logic [7:0] ascii_q [$];
    int d0, d1, e0;
    reset_n = 1'b0; en = 1'b1; abort = 1'b0;
    unread0 = 1'b0; unread1 = 1'b0; tx_ready0 = 1'b0; tx_ready1 = 1'b0;
    for (int i = 0; i < 256; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_rd_addr", rd_addr0, 0);
    check_val("reset_tx_data", tx_data0, 0);
    check_val("reset_tx_valid", tx_valid0, 0);
    check_val("reset_tx_last", tx_last0, 0);
    check_val("reset_rd_done", rd_done0, 0);
    check_val("reset_busy", busy0, 0);
    check_val("reset_len_err", len_err0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    ascii_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check_val("crc_model_check", crc_model(ascii_q), 16'h4B37);

    // en low blocks the start of a frame
    en = 1'b0; unread0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("en_blocks_start", busy0, 0);
    unread0 = 1'b0; en = 1'b1;

    // basic frame, immediate ready
    mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h02; mem0[3] = 8'hAA; mem0[4] = 8'h55;
    build_exp(0, 1);
    d0 = done_cnt0; e0 = lenerr_cnt0;
    run_frame(0, 100, -1, 0);
    check_val("basic_done_cnt", done_cnt0 - d0, 1);
    check_val("basic_no_len_err", lenerr_cnt0 - e0, 0);

    // same frame under 30% ready
    d0 = done_cnt0;
    run_frame(0, 30, -1, 0);
    check_val("bp_done_cnt", done_cnt0 - d0, 1);

    // no-CRC build, zero-length payload
    mem1[0] = 8'h05; mem1[1] = 8'h06; mem1[2] = 8'h00;
    build_exp(1, 0);
    d1 = done_cnt1;
    run_frame(1, 100, -1, 0);
    check_val("nocrc_done_cnt", done_cnt1 - d1, 1);
    check_val("nocrc_dut0_idle", busy0, 0);

    // clamp: len 0xFF gives 256 bytes then CRC
    for (int i = 0; i < 256; i++) mem0[i] = 8'(i * 7 + 3);
    mem0[2] = 8'hFF;
    build_exp(0, 1);
    d0 = done_cnt0; e0 = lenerr_cnt0;
    run_frame(0, 100, -1, 0);
    check_val("clamp_len_err", lenerr_cnt0 - e0, 1);
    check_val("clamp_exp_size", exp_q.size(), 258);
    check_val("clamp_done_cnt", done_cnt0 - d0, 1);

    // abort at byte 3, then a clean frame
    mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h02; mem0[3] = 8'hAA; mem0[4] = 8'h55;
    build_exp(0, 1);
    d0 = done_cnt0;
    run_frame(0, 100, 3, 1);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_done_cnt", done_cnt0 - d0, 1);
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h01; mem0[3] = 8'h3C;
    build_exp(0, 1);
    run_frame(0, 100, -1, 0);

    // reset mid-SEND, then restart
    d0 = done_cnt0;
    run_frame(0, 100, 2, 2);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_no_rd_done", done_cnt0 - d0, 0);
    run_frame(0, 100, -1, 0);
    check_val("rst_restart_done", done_cnt0 - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_frame_fetch.md
Name: tx_frame_fetch

Overview:
- Downstream consumer of the ping-pong frame buffer on the transmit path.
- When a frame is pending, it reads the frame bytes by address: src, dst, len, then len data bytes.
- It presents the bytes one at a time on a valid/ready stream to the bit serializer, then appends the CRC-16/MODBUS (low byte first).
- After the last byte is accepted it pulses rd_done so the buffer advances to the next page.

Parameters:
- A_WIDTH, 8: buffer address width; must match the buffer's rd_addr width.
- CRC_EN, 1: 1 = append 2 CRC bytes; 0 = end the frame after the last data byte.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- en  in  1  fetch enable; 0 blocks the start of a new frame only
- abort  in  1  one-cycle pulse; drops the current frame
- unread  in  1  buffer has at least one complete frame
- rd_addr  out  A_WIDTH  buffer byte address
- rd_byte  in  8  buffer data, valid 1 clk after rd_addr
- rd_done  out  1  one-cycle pulse: frame consumed, release page
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts when tx_valid & tx_ready
- tx_last  out  1  marks the final byte of the frame (qualifies tx_data)
- busy  out  1  frame in progress (any state other than IDLE)
- len_err  out  1  one-cycle pulse: len clamped

Behaviour:
- Reset (reset_n=0 at a clk edge) forces IDLE from any state. Reset values: rd_addr=0, tx_data=0, tx_valid=0, tx_last=0, rd_done=0, busy=0, len_err=0, crc=16'hFFFF, byte counter=0.
- FSM states: IDLE, LEN_RD, LEN_LAT, B_RD, B_LAT, SEND, CRC_L, CRC_H, DONE.
- IDLE:
  - Leave when en & unread & !abort.
  - Drive rd_addr=2, crc=FFFF, then go to LEN_RD.
- LEN_RD: wait one cycle for buffer latency, then go to LEN_LAT.
- LEN_LAT:
  - Capture total = 3 + rd_byte, using A_WIDTH+1 bit arithmetic.
  - If total > 2**A_WIDTH, clamp total to 2**A_WIDTH and pulse len_err.
  - Set idx=0, rd_addr=0, then go to B_RD.
- B_RD: wait one cycle, then go to B_LAT.
- B_LAT:
  - tx_data <= rd_byte; tx_valid <= 1.
  - tx_last <= (idx == total-1) & !CRC_EN.
  - Go to SEND.
- SEND: hold tx_data, tx_valid and tx_last stable until tx_ready. On the handshake cycle:
  - crc <= crc_update(crc, tx_data); tx_valid <= 0.
  - idx <= idx + 1.
  - If idx == total-1: go to CRC_L if CRC_EN, else DONE.
  - Otherwise: rd_addr <= idx + 1, go to B_RD.
- Throughput is one byte per 3 clk minimum (B_RD, B_LAT, SEND with immediate ready).
- crc_update:
  - Reflected CRC-16/MODBUS: poly 0xA001, init 0xFFFF, no final XOR.
  - Byte-wise: crc ^= byte, then 8 iterations of shift-right with conditional XOR 0xA001. Combinational within one cycle.
- CRC_L:
  - tx_data = crc[7:0], tx_valid = 1, tx_last = 0.
  - Go to CRC_H on handshake.
- CRC_H:
  - tx_data = crc[15:8], tx_valid = 1, tx_last = 1.
  - Go to DONE on handshake.
- DONE: rd_done = 1 for exactly one clk, then go to IDLE. At least one IDLE cycle between frames.
- abort:
  - In any non-IDLE state, go to IDLE on the next clk with tx_valid=0.
  - rd_done is pulsed in that same transition, so the aborted page is discarded.
  - abort in IDLE has no effect.
  - abort in the DONE cycle: rd_done is still pulsed exactly once.
- en deasserted mid-frame: the frame completes normally.
- unread dropping mid-frame is ignored; unread is sampled only in IDLE.
- tx_ready asserted while tx_valid=0 is ignored.
- busy = (state != IDLE).
- len=0 with CRC_EN=1: 3 header bytes + 2 CRC bytes; tx_last is on the CRC high byte.
- Addressing: rd_addr never exceeds 2**A_WIDTH-1, and idx wrap is impossible due to the clamp.

Test Plan:
- Basic frame: buffer {0x01,0x02,0x02,0xAA,0x55}, unread=1, tx_ready=1 → stream 01 02 02 AA 55 + CRC_L, CRC_H matching the golden CRC-16/MODBUS model; tx_last only on CRC_H; one rd_done pulse after that handshake. The model is self-checked to give 0x4B37 on ASCII "123456789".
- Backpressure: same frame, tx_ready toggled randomly with 30% duty → tx_data/tx_valid stable while stalled, identical byte sequence, no duplicate or dropped bytes.
- len=0 and CRC_EN=0 build: frame {0x05,0x06,0x00} → exactly 3 bytes with tx_last on 0x00; rd_done 1 clk after the last handshake.
- Clamp: A_WIDTH=8, len=0xFF → len_err pulse; exactly 256 bytes before the CRC.
- Abort mid-data at byte idx 3 → tx_valid low next clk, one rd_done, busy=0. The next pending frame then starts cleanly with crc reinitialised to FFFF.
- Reset mid-SEND (reset_n=0 for 1 clk) → all outputs at reset values on the following clk, no rd_done pulse; fetch restarts from rd_addr=2 when unread=1.
